// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM management bus between the reconfig sequencer and pll_cfg.
// The master drives write/address/data; the slave answers with waitrequest.
interface pll_reconfig_seq_if;
    logic        mgmt_waitrequest;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;

    modport master (
        input  mgmt_waitrequest,
        output mgmt_write,
        output mgmt_address,
        output mgmt_writedata
    );

    modport slave (
        output mgmt_waitrequest,
        input  mgmt_write,
        input  mgmt_address,
        input  mgmt_writedata
    );
endinterface

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: picks native/underclock/bootleg timing and
// writes mode -> fractional-K -> start into pll_cfg over Avalon-MM.
module pll_reconfig_seq #(
    parameter logic [31:0] FRAC_NATIVE   = 32'd3639383488,
    parameter logic [31:0] FRAC_UNDER    = 32'd2977614927,
    parameter logic [31:0] FRAC_BOOT     = 32'd2748778984,
    parameter int          STABLE_CYCLES = 2,
    parameter int          GAP_CYCLES    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     underclock,
    input  logic                     bootleg,
    pll_reconfig_seq_if.master       mgmt,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               applied_mode
);

    localparam logic [3:0] STB_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MODE,
        S_GAP_A,
        S_WR_FRAC,
        S_GAP_B,
        S_WR_START,
        S_FIN
    } state_t;

    logic [1:0]      w_raw;
    logic [1:0]      r_s1;
    logic [1:0]      r_s2;
    logic [1:0]      r_filt;
    logic [1:0][3:0] r_cnt;
    logic [1:0]      w_target;

    state_t          r_state, w_state_n;
    logic [1:0]      r_seq, w_seq_n;
    logic [3:0]      r_gap, w_gap_n;
    logic            r_write, w_write_n;
    logic [5:0]      r_addr, w_addr_n;
    logic [31:0]     r_data, w_data_n;
    logic            r_busy, w_busy_n;
    logic            r_done, w_done_n;
    logic [1:0]      r_applied, w_applied_n;

    assign w_raw = {bootleg, underclock};

    // A mismatch between the two sync stages means the next sample changes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_filt <= '0;
            r_cnt  <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < 2; i++) begin
                if (r_s1[i] != r_s2[i])
                    r_cnt[i] <= '0;
                else if (r_cnt[i] != STB_LAST)
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                if (r_cnt[i] == STB_LAST)
                    r_filt[i] <= r_s2[i];
            end
        end
    end

    assign w_target = r_filt[1] ? 2'd2 :
                      r_filt[0] ? 2'd1 : 2'd0;

    function automatic logic [31:0] frac_of(input logic [1:0] m);
        case (m)
            2'd1:    frac_of = FRAC_UNDER;
            2'd2:    frac_of = FRAC_BOOT;
            default: frac_of = FRAC_NATIVE;
        endcase
    endfunction

    always_comb begin
        w_state_n   = r_state;
        w_seq_n     = r_seq;
        w_gap_n     = r_gap;
        w_write_n   = 1'b0;
        w_addr_n    = r_addr;
        w_data_n    = r_data;
        w_busy_n    = r_busy;
        w_done_n    = 1'b0;
        w_applied_n = r_applied;
        unique case (r_state)
            S_IDLE: begin
                if (w_target != r_applied) begin
                    w_seq_n   = w_target;
                    w_busy_n  = 1'b1;
                    w_state_n = S_WR_MODE;
                end
            end
            S_WR_MODE: begin
                if (!mgmt.mgmt_waitrequest) begin
                    w_write_n = 1'b1;
                    w_addr_n  = 6'd0;
                    w_data_n  = 32'd0;
                    w_gap_n   = '0;
                    w_state_n = S_GAP_A;
                end
            end
            S_GAP_A: begin
                if (r_gap == GAP_LAST)
                    w_state_n = S_WR_FRAC;
                else
                    w_gap_n = r_gap + 4'd1;
            end
            S_WR_FRAC: begin
                if (!mgmt.mgmt_waitrequest) begin
                    w_write_n = 1'b1;
                    w_addr_n  = 6'd7;
                    w_data_n  = frac_of(r_seq);
                    w_gap_n   = '0;
                    w_state_n = S_GAP_B;
                end
            end
            S_GAP_B: begin
                if (r_gap == GAP_LAST)
                    w_state_n = S_WR_START;
                else
                    w_gap_n = r_gap + 4'd1;
            end
            S_WR_START: begin
                if (!mgmt.mgmt_waitrequest) begin
                    w_write_n = 1'b1;
                    w_addr_n  = 6'd2;
                    w_data_n  = 32'd0;
                    w_state_n = S_FIN;
                end
            end
            S_FIN: begin
                w_applied_n = r_seq;
                w_done_n    = 1'b1;
                w_busy_n    = 1'b0;
                w_state_n   = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_seq     <= '0;
            r_gap     <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_applied <= '0;
        end else begin
            r_state   <= w_state_n;
            r_seq     <= w_seq_n;
            r_gap     <= w_gap_n;
            r_write   <= w_write_n;
            r_addr    <= w_addr_n;
            r_data    <= w_data_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
            r_applied <= w_applied_n;
        end
    end

    assign mgmt.mgmt_write     = r_write;
    assign mgmt.mgmt_address   = r_addr;
    assign mgmt.mgmt_writedata = r_data;
    assign busy                = r_busy;
    assign done                = r_done;
    assign applied_mode        = r_applied;

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Sequencer driving the Avalon-MM management port of the Altera PLL reconfiguration block (pll_cfg).
- Selects the video/CPU clock mode from the OSD underclock option and the bootleg ROM-header flag.
- Issues the fixed write sequence mode → fractional-K → start, honouring waitrequest.
- Sits between the emu-level status/ROM-header logic and pll_cfg, on the 50 MHz management clock.

Parameters:
- FRAC_NATIVE, 32'd3639383488, fractional-K word for native timing (mode 0).
- FRAC_UNDER, 32'd2977614927, fractional-K word for the 60 Hz underclock (mode 1).
- FRAC_BOOT, 32'd2748778984, fractional-K word for bootleg PCB timing (mode 2).
- STABLE_CYCLES, 2, consecutive identical synchronized samples required before a request is accepted (range 1..15).
- GAP_CYCLES, 3, idle cycles inserted after each issued write (range 0..15).

Ports:
- clk, in, 1, management clock (CLK_50M).
- reset, in, 1, synchronous, active-high.
- underclock, in, 1, asynchronous level from another clock domain (status[21]).
- bootleg, in, 1, asynchronous level; high when is_bootleg == 2'b10.
- mgmt_waitrequest, in, 1, from pll_cfg.
- mgmt_write, out, 1, one-cycle write strobe.
- mgmt_address, out, 6, register address.
- mgmt_writedata, out, 32, register data.
- busy, out, 1, high while a sequence is in progress.
- done, out, 1, one-cycle pulse when a sequence completes.
- applied_mode, out, 2, last mode fully written: 0 native, 1 under, 2 boot.

Behaviour:
- Reset values:
  - mgmt_write = 0, mgmt_address = 0, mgmt_writedata = 0, busy = 0, done = 0, applied_mode = 0.
  - Synchronizers and stability counters are cleared.
  - target_mode = 0 (the PLL power-up default is native).
- Input synchronization:
  - Each of underclock and bootleg passes through a 2-FF synchronizer.
  - A per-input counter increments while the synchronized value equals its previous sample and resets to 0 on a change.
  - When the counter reaches STABLE_CYCLES-1, the filtered value takes the synchronized value.
- target_mode = 2 if bootleg_filt, else 1 if underclock_filt, else 0. Bootleg has priority.
- FSM states: IDLE, WR_MODE, GAP_A, WR_FRAC, GAP_B, WR_START, FIN.
- IDLE:
  - If target_mode != applied_mode, latch seq_mode = target_mode, set busy = 1, and go to WR_MODE on the next cycle.
- WR_MODE, WR_FRAC, WR_START:
  - If mgmt_waitrequest = 1, hold the state with mgmt_write = 0.
  - Otherwise assert mgmt_write for exactly 1 cycle and advance.
  - Register contents per state:
    - WR_MODE: address 0, data 0 (waitrequest mode).
    - WR_FRAC: address 7, data = FRAC word for seq_mode.
    - WR_START: address 2, data 0.
  - Address and data are registered together with mgmt_write and hold their values after the strobe until the next write.
- GAP_A and GAP_B:
  - Count GAP_CYCLES cycles with mgmt_write = 0, then advance.
  - With GAP_CYCLES = 0, the next write state is entered on the cycle after the strobe.
- WR_START → FIN (1 cycle): applied_mode = seq_mode, done = 1, busy = 0, then go to IDLE.
- Latency:
  - With waitrequest held low, GAP_CYCLES = 3 and STABLE_CYCLES = 2, the first strobe occurs 2 (sync) + 1 (stable) + 1 (target) + 1 (IDLE) cycles after an input edge, with a ±1 cycle synchronizer tolerance.
  - Strobes are spaced exactly GAP_CYCLES + 2 cycles apart (5 at the default).
- Input change mid-sequence:
  - The running sequence is never aborted; seq_mode stays latched.
  - After FIN, IDLE re-compares target_mode with applied_mode and starts a new sequence if they differ.
  - Inputs that toggle and return within a sequence cause no extra sequence.
- Glitch shorter than STABLE_CYCLES synchronized cycles: ignored, target_mode unchanged.
- Reset mid-sequence:
  - Immediate return to IDLE with all outputs at their reset values.
  - Any strobe in that cycle is suppressed.
  - If the inputs still demand mode ≠ 0 after reset, a full fresh sequence runs.
- mgmt_write is never high in two consecutive cycles, and is never high while busy = 0.

Test Plan:
- Reset with underclock = 0, bootleg = 0, waitrequest = 0, run 50 cycles → no mgmt_write, busy = 0, applied_mode = 0.
- underclock 0→1, waitrequest = 0 → three strobes 5 cycles apart: (addr 0, data 0), (addr 7, data 2977614927), (addr 2, data 0); done pulses 1 cycle after the third; applied_mode = 1.
- underclock = 1 and bootleg = 1 together → FRAC write carries 2748778984; applied_mode = 2. Then bootleg → 0 → new sequence with 2977614927.
- waitrequest held high for 20 cycles at WR_FRAC → mgmt_write stays 0 and addr 0 / data 0 hold. Waitrequest released → strobe addr 7 on the first low cycle.
- 1-cycle underclock pulse → no sequence. underclock toggled 1 → 0 during GAP_A of a mode-1 sequence → mode-1 sequence completes (applied_mode = 1), then a mode-0 sequence with 3639383488 follows.
- Reset asserted 1 cycle after the WR_MODE strobe with underclock = 1 → outputs zero during reset; after release a complete 3-write mode-1 sequence is issued.
